// File: rtl/module_control_hamming_pkg.sv
// Shared types and helpers for the Hamming(7,4) transmit path.
package pkg_hamming;

  localparam int DATA_W = 4;
  localparam int CODE_W = 7;

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} tx_state_t;

  // Position 0 means "no error"; 1..7 selects a single codeword bit to invert.
  function automatic logic [CODE_W-1:0] err_mask(input logic [2:0] err_pos);
    logic [CODE_W-1:0] mask;
    mask = '0;
    if (err_pos != 3'd0) begin
      mask = CODE_W'(1) << (err_pos - 3'd1);
    end
    return mask;
  endfunction

endpackage

// File: rtl/module_control_hamming_codificador.sv
// Combinational Hamming(7,4) encoder; codeword bit i holds Hamming position i+1.
module module_codificador
  import pkg_hamming::*;
(
  input  logic [DATA_W-1:0] datos,
  output logic [CODE_W-1:0] codigo
);

  logic p1, p2, p3;

  assign p1 = datos[0] ^ datos[1] ^ datos[3];
  assign p2 = datos[0] ^ datos[2] ^ datos[3];
  assign p3 = datos[1] ^ datos[2] ^ datos[3];

  assign codigo = {datos[3], datos[2], datos[1], p3, datos[0], p2, p1};

endmodule

// File: rtl/module_control_hamming.sv
// Transmit controller: accepts a nibble, encodes it, optionally corrupts one bit,
// and shifts the codeword out as start + 7 data bits (LSB first) + stop.
module module_control_hamming
  import pkg_hamming::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] datos_in,
  input  logic [2:0]        err_pos,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              tx_out,
  output logic [CODE_W-1:0] cod_out,
  output logic              busy,
  output logic              done
);

  localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_BIT = 3'(CODE_W - 1);

  tx_state_t         state, state_next;
  logic [CNT_W-1:0]  clk_cnt, clk_cnt_next;
  logic [2:0]        bit_cnt, bit_cnt_next;
  logic [DATA_W-1:0] datos_q;
  logic [2:0]        err_q;
  logic [CODE_W-1:0] enc_code;
  logic [CODE_W:0]   cod_ext;
  logic              tx_next;
  logic              done_next;
  logic              accept;
  logic              bit_end;

  module_codificador u_codificador (
    .datos  (datos_q),
    .codigo (enc_code)
  );

  assign ready_out = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = valid_in & ready_out;
  assign bit_end   = (clk_cnt == CNT_LAST);
  // Padding bit keeps the 3-bit index in range without a width warning.
  assign cod_ext   = {1'b1, cod_out};

  always_comb begin
    state_next   = state;
    clk_cnt_next = clk_cnt;
    bit_cnt_next = bit_cnt;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_next = '0;
        if (accept) state_next = LOAD;
      end
      LOAD: begin
        clk_cnt_next = '0;
        state_next   = START;
      end
      START: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          bit_cnt_next = '0;
          state_next   = DATA;
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          if (bit_cnt == LAST_BIT) state_next = STOP;
          else                     bit_cnt_next = bit_cnt + 3'd1;
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          state_next   = IDLE;
          done_next    = 1'b1;
        end else begin
          clk_cnt_next = clk_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // The line is registered, so it is driven from the state being entered.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = cod_ext[bit_cnt_next];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      datos_q <= '0;
      err_q   <= '0;
      cod_out <= '0;
      tx_out  <= 1'b1;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      clk_cnt <= clk_cnt_next;
      bit_cnt <= bit_cnt_next;
      if (accept) begin
        datos_q <= datos_in;
        err_q   <= err_pos;
      end
      if (state == LOAD) cod_out <= enc_code ^ err_mask(err_q);
      tx_out  <= tx_next;
      done    <= done_next;
    end
  end

endmodule

// File: tb/tb_module_control_hamming.sv
// Bench for module_control_hamming: scoreboarded frames checked bit-by-bit on the serial line.
module tb_module_control_hamming;
  import pkg_hamming::*;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] datos_in;
  logic [2:0] err_pos;
  logic       valid_in;
  logic       ready_out, tx_out, busy, done;
  logic [6:0] cod_out;

  logic [3:0] datos_b;
  logic [2:0] err_b;
  logic       valid_b;
  logic       ready_b, tx_b, busy_b, done_b;
  logic [6:0] cod_b;

  int total = 0;
  int bad   = 0;
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  module_control_hamming #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .rst_n(rst_n), .datos_in(datos_in), .err_pos(err_pos), .valid_in(valid_in),
    .ready_out(ready_out), .tx_out(tx_out), .cod_out(cod_out), .busy(busy), .done(done)
  );

  module_control_hamming #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .datos_in(datos_b), .err_pos(err_b), .valid_in(valid_b),
    .ready_out(ready_b), .tx_out(tx_b), .cod_out(cod_b), .busy(busy_b), .done(done_b)
  );

  // Reference encoder built from Hamming positions: parity p covers every position with bit p set.
  function automatic logic [6:0] modelEncode(input logic [3:0] d, input logic [2:0] e);
    logic [7:1] w;
    int k;
    w = '0;
    k = 0;
    for (int p = 1; p <= 7; p++) begin
      if (p != 1 && p != 2 && p != 4) begin
        w[p] = d[k];
        k++;
      end
    end
    for (int p = 1; p <= 4; p = p * 2) begin
      for (int q = 3; q <= 7; q++) begin
        if ((q & p) != 0 && q != p) w[p] = w[p] ^ w[q];
      end
    end
    if (e != 3'd0) w[e] = ~w[e];
    return w;
  endfunction

  // Expected line level in cycle cyc after the accept edge (cycle 1 is LOAD).
  function automatic logic expLevel(input int n, input int cyc, input logic [6:0] code);
    if (cyc >= 2 && cyc <= 1 + n) return 1'b0;
    if (cyc >= 2 + n && cyc <= 1 + 8 * n) return code[(cyc - 2 - n) / n];
    return 1'b1;
  endfunction

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] d, input logic [2:0] e);
    int guard;
    @(negedge clk);
    datos_in = d;
    err_pos  = e;
    valid_in = 1'b1;
    exp_q.push_back(modelEncode(d, e));
    guard = 0;
    while (ready_out !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    compare("accept_wait", guard < 100, 1);
    @(posedge clk);
  endtask

  // Follows one frame to its done pulse; nd/ne are driven from cycle 1 on, hold keeps valid up,
  // and pulse (if nonzero) raises valid for one cycle mid-frame.
  task automatic checkOutput(input logic [3:0] nd, input logic [2:0] ne, input bit hold, input int pulse);
    logic [6:0] exp_code, got;
    int cyc, busy_cyc, wave_err;
    bit seen_done;
    exp_code = '0;
    if (exp_q.size() == 0) compare("scoreboard_empty", 0, 1);
    else exp_code = exp_q.pop_front();
    got = '0;
    cyc = 0;
    busy_cyc = 0;
    wave_err = 0;
    seen_done = 0;
    while (!seen_done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        datos_in = nd;
        err_pos  = ne;
        valid_in = hold;
      end
      if (pulse != 0 && cyc == pulse) valid_in = 1'b1;
      if (pulse != 0 && cyc == pulse + 1) valid_in = 1'b0;
      if (done === 1'b1) begin
        seen_done = 1;
      end else begin
        if (busy === 1'b1) busy_cyc++;
        if (tx_out !== expLevel(N, cyc, exp_code)) wave_err++;
        if (cyc >= 2 + N && cyc <= 1 + 8 * N && ((cyc - 2 - N) % N) == N / 2)
          got[(cyc - 2 - N) / N] = tx_out;
      end
    end
    compare("done_cycle", cyc, 2 + 9 * N);
    compare("busy_cycles", busy_cyc, 1 + 9 * N);
    compare("tx_wave_errors", wave_err, 0);
    compare("rx_code", got, exp_code);
    compare("cod_out", cod_out, exp_code);
    compare("ready_at_done", ready_out, 1);
  endtask

  task automatic runFrameN1(input logic [3:0] d, input logic [2:0] e);
    logic [6:0] exp_code;
    int cyc, wave_err;
    bit seen_done;
    @(negedge clk);
    compare("n1_ready", ready_b, 1);
    datos_b = d;
    err_b   = e;
    valid_b = 1'b1;
    exp_q.push_back(modelEncode(d, e));
    @(posedge clk);
    exp_code = exp_q.pop_front();
    cyc = 0;
    wave_err = 0;
    seen_done = 0;
    while (!seen_done && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) valid_b = 1'b0;
      if (done_b === 1'b1) seen_done = 1;
      else if (tx_b !== expLevel(1, cyc, exp_code)) wave_err++;
    end
    compare("n1_done_cycle", cyc, 11);
    compare("n1_tx_wave_errors", wave_err, 0);
    compare("n1_cod_out", cod_b, exp_code);
  endtask

  initial begin
    int done_seen;
    rst_n    = 1'b0;
    datos_in = '0;
    err_pos  = '0;
    valid_in = 1'b0;
    datos_b  = '0;
    err_b    = '0;
    valid_b  = 1'b0;

    $display("[TB] reset");
    repeat (2) @(negedge clk);
    compare("rst_tx", tx_out, 1);
    compare("rst_ready", ready_out, 1);
    compare("rst_busy", busy, 0);
    compare("rst_done", done, 0);
    compare("rst_cod", cod_out, 7'b0000000);
    rst_n = 1'b1;

    $display("[TB] single frames");
    applyStimulus(4'b0000, 3'd0);
    checkOutput(4'b0101, 3'd6, 1'b0, 0);
    @(negedge clk);
    compare("done_one_cycle", done, 0);
    compare("idle_busy", busy, 0);
    applyStimulus(4'b1111, 3'd0);
    checkOutput(4'b0000, 3'd1, 1'b0, 0);
    applyStimulus(4'b0000, 3'd3);
    checkOutput(4'b1111, 3'd7, 1'b0, 0);
    applyStimulus(4'b1111, 3'd7);
    checkOutput(4'b0000, 3'd0, 1'b0, 0);
    applyStimulus(4'b1011, 3'd0);
    checkOutput(4'b0000, 3'd0, 1'b0, 0);
    applyStimulus(4'b0110, 3'd5);
    checkOutput(4'b0000, 3'd0, 1'b0, 0);

    $display("[TB] back-to-back and ignored request");
    applyStimulus(4'b1111, 3'd0);
    exp_q.push_back(modelEncode(4'b0000, 3'd0));
    checkOutput(4'b0000, 3'd0, 1'b1, 0);
    checkOutput(4'b0000, 3'd0, 1'b0, 0);
    applyStimulus(4'b1001, 3'd2);
    checkOutput(4'b0011, 3'd0, 1'b0, 10);
    @(negedge clk);
    compare("ignored_pulse_busy", busy, 0);
    compare("ignored_pulse_ready", ready_out, 1);

    $display("[TB] reset mid-frame");
    applyStimulus(4'b1111, 3'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    valid_in = 1'b0;
    repeat (22) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    compare("abort_tx", tx_out, 1);
    compare("abort_busy", busy, 0);
    compare("abort_cod", cod_out, 7'b0000000);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    compare("abort_no_done", done_seen, 0);
    applyStimulus(4'b1111, 3'd0);
    checkOutput(4'b0000, 3'd0, 1'b0, 0);

    $display("[TB] one clock per bit");
    runFrameN1(4'b0000, 3'd0);
    runFrameN1(4'b1101, 3'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
